uart_tx_fifo: RTL and testbench

Parametrised, single-clock UART transmitter with an internal baud divider and a transmit FIFO. It generalises the team's fixed 8N1/8x1 transmit path:
- data width 5–9 bits
- five parity modes
- configurable stop bits and FIFO depth
- break generation
- overflow reporting

It sits between a host write port and the tx pin. The host can queue a burst of words, and the block sends them back-to-back with no idle gap.

---
 rtl/uart_tx_fifo.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_fifo : UART transmitter with baud divider, TX FIFO, break, overflow |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOPBITS     = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int WAIT_BITS    = 200
) (
    input  logic                          uart_clock,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          wr_en,
    input  logic                          send_break,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int LVL_W    = PTR_W + 1;
    localparam int MAX_BITS = (WAIT_BITS > DATA_BITS) ? WAIT_BITS : DATA_BITS;
    localparam int BIT_W    = $clog2(MAX_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  INIT_LAST = BIT_W'(WAIT_BITS - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOPBITS - 1);
    localparam logic [LVL_W-1:0]  DEPTH     = LVL_W'(FIFO_DEPTH);

    localparam logic [2:0] S_INIT       = 3'd0;
    localparam logic [2:0] S_IDLE       = 3'd1;
    localparam logic [2:0] S_START      = 3'd2;
    localparam logic [2:0] S_DATA       = 3'd3;
    localparam logic [2:0] S_PARITY     = 3'd4;
    localparam logic [2:0] S_STOP       = 3'd5;
    localparam logic [2:0] S_BREAK      = 3'd6;
    localparam logic [2:0] S_BREAK_IDLE = 3'd7;

    logic [2:0]           state_q, state_d;
    logic [BAUD_W-1:0]    baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 full_q, full_d, empty_q, empty_d;
    logic                 overflow_q, overflow_d;
    logic [DATA_BITS-1:0] fifo_mem_q [FIFO_DEPTH];

    logic                 bit_end, push, pop, head_parity;
    logic [DATA_BITS-1:0] head;

    always_comb begin
        bit_end   = (baud_cnt_q == BAUD_LAST);
        push      = wr_en && !full_q;
        pop       = 1'b0;
        head      = fifo_mem_q[rd_ptr_q];
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;

        case (PARITY)
            1:       head_parity = ~^head;
            2:       head_parity = ^head;
            3:       head_parity = 1'b1;
            default: head_parity = 1'b0;
        endcase

        case (state_q)
            S_INIT: if (bit_end) begin
                if (bit_cnt_q == INIT_LAST) state_d = S_IDLE;
                else                        bit_cnt_d = bit_cnt_q + 1'b1;
            end
            S_IDLE: begin
                if (send_break) begin
                    state_d = S_BREAK;
                end else if (!empty_q) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                if (bit_cnt_q == DATA_LAST) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                else                        bit_cnt_d = bit_cnt_q + 1'b1;
            end
            S_PARITY: if (bit_end) state_d = S_STOP;
            // Frame end: break outranks a waiting word; a waiting word skips IDLE.
            S_STOP: if (bit_end) begin
                if (bit_cnt_q == STOP_LAST) begin
                    if (send_break) begin
                        state_d = S_BREAK;
                    end else if (!empty_q) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_BREAK:      if (!send_break) state_d = S_BREAK_IDLE;
            S_BREAK_IDLE: if (bit_end) state_d = S_IDLE;
            default:      state_d = S_INIT;
        endcase

        if (pop) begin
            shift_d  = head;
            parity_d = head_parity;
        end

        if (state_d != state_q) begin
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
        end else begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
        end

        // tx is registered, so it is decoded from the next state to stay aligned with it.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            S_BREAK:  tx_d = 1'b0;
            default:  tx_d = 1'b1;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;
        full_d     = (level_d == DEPTH);
        empty_d    = (level_d == '0);
        overflow_d = wr_en && full_q;
    end

    always_ff @(posedge uart_clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_INIT;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge uart_clock) begin
        if (push && !reset) fifo_mem_q[wr_ptr_q] <= wr_data;
    end

    assign tx         = tx_q;
    assign tx_busy    = (state_q != S_IDLE);
    assign fifo_empty = empty_q;
    assign fifo_full  = full_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_fifo : directed self-checking bench for uart_tx_fifo            |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_uart_tx_fifo;
    logic       uart_clock = 1'b0;
    logic       reset      = 1'b1;
    logic [8:0] wr_data    [4];
    logic       wr_en      [4];
    logic       send_break [4];
    logic       tx_w [4], busy_w [4], empty_w [4], full_w [4], ovf_w [4];
    logic [4:0] lvl_w [4];
    int         checks   = 0;
    int         failures = 0;

    always #5 uart_clock = ~uart_clock;

    // 0: 8N1 WAIT 2   1: 8N1 WAIT 8   2: 8E1 WAIT 2   3: 9 data, odd parity, 2 stop, WAIT 2
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOPBITS(1), .FIFO_DEPTH(16), .WAIT_BITS(2)) u_a (
        .uart_clock(uart_clock), .reset(reset), .wr_data(wr_data[0][7:0]), .wr_en(wr_en[0]),
        .send_break(send_break[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .fifo_empty(empty_w[0]),
        .fifo_full(full_w[0]), .fifo_level(lvl_w[0]), .overflow(ovf_w[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOPBITS(1), .FIFO_DEPTH(16), .WAIT_BITS(8)) u_b (
        .uart_clock(uart_clock), .reset(reset), .wr_data(wr_data[1][7:0]), .wr_en(wr_en[1]),
        .send_break(send_break[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .fifo_empty(empty_w[1]),
        .fifo_full(full_w[1]), .fifo_level(lvl_w[1]), .overflow(ovf_w[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOPBITS(1), .FIFO_DEPTH(16), .WAIT_BITS(2)) u_c (
        .uart_clock(uart_clock), .reset(reset), .wr_data(wr_data[2][7:0]), .wr_en(wr_en[2]),
        .send_break(send_break[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .fifo_empty(empty_w[2]),
        .fifo_full(full_w[2]), .fifo_level(lvl_w[2]), .overflow(ovf_w[2]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(9), .PARITY(1), .STOPBITS(2), .FIFO_DEPTH(16), .WAIT_BITS(2)) u_d (
        .uart_clock(uart_clock), .reset(reset), .wr_data(wr_data[3]), .wr_en(wr_en[3]),
        .send_break(send_break[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .fifo_empty(empty_w[3]),
        .fifo_full(full_w[3]), .fifo_level(lvl_w[3]), .overflow(ovf_w[3]));

    task automatic tick();
        @(posedge uart_clock);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 4; i++) begin
            wr_data[i] = '0; wr_en[i] = 1'b0; send_break[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Expected per-cycle tx waveform of one frame at 4 clocks per bit, cycle k in bit k.
    function automatic logic [63:0] frame_wave(input logic [8:0] word, input int dbits,
                                               input int par, input int stops);
        logic [15:0] b;
        logic        p;
        int          n;
        logic [63:0] w;
        b = '1; b[0] = 1'b0; p = 1'b0;
        for (int i = 0; i < dbits; i++) begin
            b[1+i] = word[i];
            p = p ^ word[i];
        end
        n = 1 + dbits;
        if (par != 0) begin
            case (par)
                1:       b[n] = ~p;
                2:       b[n] = p;
                3:       b[n] = 1'b1;
                default: b[n] = 1'b0;
            endcase
            n++;
        end
        n = n + stops;
        w = '0;
        for (int k = 0; k < n * 4; k++) w[k] = b[k/4];
        return w;
    endfunction

    task automatic capture(input int sel, input int ncyc, output logic [63:0] got);
        got = '0;
        for (int k = 0; k < ncyc; k++) begin
            got[k] = tx_w[sel];
            if (k != ncyc - 1) tick();
        end
    endtask

    task automatic wait_start(input int sel, input int max_cyc, output bit found);
        found = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            if (tx_w[sel] === 1'b0) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        checks += 6;
        if (tx_w[0] !== 1'b1)    begin failures++; $display("FAIL reset_tx got=%b exp=1", tx_w[0]); end
        if (busy_w[0] !== 1'b1)  begin failures++; $display("FAIL reset_busy got=%b exp=1", busy_w[0]); end
        if (empty_w[0] !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty_w[0]); end
        if (full_w[0] !== 1'b0)  begin failures++; $display("FAIL reset_full got=%b exp=0", full_w[0]); end
        if (lvl_w[0] !== 5'd0)   begin failures++; $display("FAIL reset_level got=%0d exp=0", lvl_w[0]); end
        if (ovf_w[0] !== 1'b0)   begin failures++; $display("FAIL reset_overflow got=%b exp=0", ovf_w[0]); end
        reset = 1'b0;
    endtask

    task automatic test_basic_frame();
        logic [63:0] got, exp;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (busy_w[0] !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b exp=0", busy_w[0]); end
        wr_data[0] = 9'h055; wr_en[0] = 1'b1;
        tick();
        wr_en[0] = 1'b0;
        checks += 3;
        if (empty_w[0] !== 1'b0) begin failures++; $display("FAIL basic_empty_after_wr got=%b exp=0", empty_w[0]); end
        if (lvl_w[0] !== 5'd1)   begin failures++; $display("FAIL basic_level_after_wr got=%0d exp=1", lvl_w[0]); end
        if (tx_w[0] !== 1'b1)    begin failures++; $display("FAIL basic_tx_before_pop got=%b exp=1", tx_w[0]); end
        tick();
        capture(0, 40, got);
        exp = 64'h0000_00F0_F0F0_F0F0;  // start 0, bits 1,0,1,0,1,0,1,0, stop 1
        checks += 2;
        if (got !== exp) begin failures++; $display("FAIL basic_frame got=%h exp=%h", got, exp); end
        if (busy_w[0] !== 1'b1) begin failures++; $display("FAIL basic_busy_last_stop got=%b exp=1", busy_w[0]); end
        tick();
        checks += 2;
        if (busy_w[0] !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy_w[0]); end
        if (empty_w[0] !== 1'b1) begin failures++; $display("FAIL basic_empty_after got=%b exp=1", empty_w[0]); end
    endtask

    task automatic test_parity();
        logic [63:0] got, got2;
        logic [8:0]  dbits;
        bit          found;
        wr_data[2] = 9'h007; wr_en[2] = 1'b1;
        tick();
        wr_en[2] = 1'b0;
        wait_start(2, 10, found);
        checks++;
        if (!found) begin failures++; $display("FAIL even_start_timeout got=none exp=start"); end
        capture(2, 44, got);
        checks += 2;
        if (got !== frame_wave(9'h007, 8, 2, 1)) begin failures++; $display("FAIL even_frame got=%h exp=%h", got, frame_wave(9'h007, 8, 2, 1)); end
        if (got[37] !== 1'b1) begin failures++; $display("FAIL even_parity_bit got=%b exp=1", got[37]); end

        wr_data[3] = 9'h007; wr_en[3] = 1'b1;
        tick();
        wr_data[3] = 9'h1A5;
        tick();
        wr_en[3] = 1'b0;
        wait_start(3, 10, found);
        checks++;
        if (!found) begin failures++; $display("FAIL odd_start_timeout got=none exp=start"); end
        capture(3, 52, got);
        tick();
        capture(3, 52, got2);
        for (int i = 0; i < 9; i++) dbits[i] = got2[4*(1+i)+1];
        checks += 5;
        if (got !== frame_wave(9'h007, 9, 1, 2))  begin failures++; $display("FAIL odd_frame1 got=%h exp=%h", got, frame_wave(9'h007, 9, 1, 2)); end
        if (got[41] !== 1'b0)                     begin failures++; $display("FAIL odd_parity_07 got=%b exp=0", got[41]); end
        if (got2 !== frame_wave(9'h1A5, 9, 1, 2)) begin failures++; $display("FAIL odd_frame2 got=%h exp=%h", got2, frame_wave(9'h1A5, 9, 1, 2)); end
        if (dbits !== 9'h1A5)                     begin failures++; $display("FAIL nine_bit_data got=%h exp=1a5", dbits); end
        if (got2[41] !== 1'b0)                    begin failures++; $display("FAIL odd_parity_1a5 got=%b exp=0", got2[41]); end
    endtask

    task automatic test_fifo_full();
        logic [63:0] got;
        bit          found;
        int          lows;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            wr_data[1] = 9'(i + 1); wr_en[1] = 1'b1;
            tick();
            if (i == 15) begin
                checks += 3;
                if (full_w[1] !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", full_w[1]); end
                if (lvl_w[1] !== 5'd16) begin failures++; $display("FAIL full_level got=%0d exp=16", lvl_w[1]); end
                if (ovf_w[1] !== 1'b0)  begin failures++; $display("FAIL full_no_ovf got=%b exp=0", ovf_w[1]); end
            end
        end
        wr_en[1] = 1'b0;
        checks += 2;
        if (ovf_w[1] !== 1'b1)  begin failures++; $display("FAIL overflow_pulse got=%b exp=1", ovf_w[1]); end
        if (lvl_w[1] !== 5'd16) begin failures++; $display("FAIL overflow_level got=%0d exp=16", lvl_w[1]); end
        tick();
        checks++;
        if (ovf_w[1] !== 1'b0) begin failures++; $display("FAIL overflow_one_cycle got=%b exp=0", ovf_w[1]); end
        wait_start(1, 40, found);
        checks++;
        if (!found) begin failures++; $display("FAIL full_start_timeout got=none exp=start"); end
        for (int f = 0; f < 16; f++) begin
            if (f > 0) tick();
            if (f == 15) begin
                checks++;
                if (empty_w[1] !== 1'b1) begin failures++; $display("FAIL empty_after_last_pop got=%b exp=1", empty_w[1]); end
            end
            capture(1, 40, got);
            checks++;
            if (got !== frame_wave(9'(f + 1), 8, 0, 1)) begin
                failures++; $display("FAIL burst_frame%0d got=%h exp=%h", f, got, frame_wave(9'(f + 1), 8, 0, 1));
            end
        end
        tick();
        checks++;
        if (busy_w[1] !== 1'b0) begin failures++; $display("FAIL burst_idle_busy got=%b exp=0", busy_w[1]); end
        lows = 0;
        for (int k = 0; k < 20; k++) begin
            if (tx_w[1] !== 1'b1) lows++;
            tick();
        end
        checks++;
        if (lows != 0) begin failures++; $display("FAIL dropped_word_sent got=%0d low cycles exp=0", lows); end
    endtask

    task automatic test_same_edge_pop();
        bit found;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr_data[1] = 9'(8'h40 + i); wr_en[1] = 1'b1;
            tick();
        end
        wr_en[1] = 1'b0;
        wait_start(1, 40, found);
        checks += 2;
        if (!found) begin failures++; $display("FAIL sep_start_timeout got=none exp=start"); end
        if (lvl_w[1] !== 5'd15) begin failures++; $display("FAIL sep_level_after_pop got=%0d exp=15", lvl_w[1]); end
        wr_data[1] = 9'h099; wr_en[1] = 1'b1;
        tick();
        wr_en[1] = 1'b0;
        checks += 2;
        if (lvl_w[1] !== 5'd16) begin failures++; $display("FAIL sep_refill_level got=%0d exp=16", lvl_w[1]); end
        if (full_w[1] !== 1'b1) begin failures++; $display("FAIL sep_refill_full got=%b exp=1", full_w[1]); end
        for (int k = 0; k < 38; k++) tick();
        wr_data[1] = 9'h0EE; wr_en[1] = 1'b1;
        tick();
        wr_en[1] = 1'b0;
        checks += 4;
        if (ovf_w[1] !== 1'b1)  begin failures++; $display("FAIL sep_overflow got=%b exp=1", ovf_w[1]); end
        if (lvl_w[1] !== 5'd15) begin failures++; $display("FAIL sep_level got=%0d exp=15", lvl_w[1]); end
        if (full_w[1] !== 1'b0) begin failures++; $display("FAIL sep_full got=%b exp=0", full_w[1]); end
        if (tx_w[1] !== 1'b0)   begin failures++; $display("FAIL sep_next_start got=%b exp=0", tx_w[1]); end
        tick();
        checks++;
        if (ovf_w[1] !== 1'b0) begin failures++; $display("FAIL sep_overflow_width got=%b exp=0", ovf_w[1]); end
    endtask

    task automatic test_reset_mid_frame();
        bit found;
        int highs;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_data[1] = 9'(8'h11 * i); wr_en[1] = 1'b1;
            tick();
        end
        wr_en[1] = 1'b0;
        wait_start(1, 40, found);
        checks += 2;
        if (!found) begin failures++; $display("FAIL rmf_start_timeout got=none exp=start"); end
        if (lvl_w[1] !== 5'd3) begin failures++; $display("FAIL rmf_queued got=%0d exp=3", lvl_w[1]); end
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (tx_w[1] !== 1'b0) begin failures++; $display("FAIL rmf_data_low got=%b exp=0", tx_w[1]); end
        #2 reset = 1'b1;
        #1;
        checks += 4;
        if (tx_w[1] !== 1'b1)    begin failures++; $display("FAIL rmf_tx got=%b exp=1", tx_w[1]); end
        if (lvl_w[1] !== 5'd0)   begin failures++; $display("FAIL rmf_level got=%0d exp=0", lvl_w[1]); end
        if (empty_w[1] !== 1'b1) begin failures++; $display("FAIL rmf_empty got=%b exp=1", empty_w[1]); end
        if (busy_w[1] !== 1'b1)  begin failures++; $display("FAIL rmf_busy got=%b exp=1", busy_w[1]); end
        tick(); tick();
        reset = 1'b0;
        wr_data[1] = 9'h05A; wr_en[1] = 1'b1;
        highs = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            wr_en[1] = 1'b0;
            if (tx_w[1] === 1'b1) highs++;
        end
        tick();
        checks += 2;
        if (highs != 32)      begin failures++; $display("FAIL rmf_init_hold got=%0d high cycles exp=32", highs); end
        if (tx_w[1] !== 1'b0) begin failures++; $display("FAIL rmf_first_start got=%b exp=0", tx_w[1]); end
    endtask

    task automatic test_break();
        logic [63:0] f1, f2;
        logic        e;
        bit          found;
        int          bad, first_bad;
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        wr_data[0] = 9'h0A3; wr_en[0] = 1'b1;
        tick();
        wr_en[0] = 1'b0;
        wait_start(0, 4, found);
        checks++;
        if (!found) begin failures++; $display("FAIL brk_start_timeout got=none exp=start"); end
        f1 = frame_wave(9'h0A3, 8, 0, 1);
        f2 = frame_wave(9'h03C, 8, 0, 1);
        bad = 0; first_bad = -1;
        // BREAK_IDLE is one bit period, then one IDLE cycle before the queued word pops.
        for (int k = 0; k <= 155; k++) begin
            if (k < 40)       e = f1[k];
            else if (k < 111) e = 1'b0;
            else if (k < 116) e = 1'b1;
            else              e = f2[k-116];
            if (tx_w[0] !== e) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
            if (k == 10) begin send_break[0] = 1'b1; wr_data[0] = 9'h03C; wr_en[0] = 1'b1; end
            if (k == 11) wr_en[0] = 1'b0;
            if (k == 110) send_break[0] = 1'b0;
            if (k < 155) tick();
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL break_sequence got=%0d bad cycles (first at %0d) exp=0", bad, first_bad); end
        tick();
        checks++;
        if (busy_w[0] !== 1'b0) begin failures++; $display("FAIL brk_back_idle got=%b exp=0", busy_w[0]); end
        send_break[0] = 1'b1;
        tick();
        checks += 2;
        if (tx_w[0] !== 1'b0)   begin failures++; $display("FAIL brk_from_idle_tx got=%b exp=0", tx_w[0]); end
        if (busy_w[0] !== 1'b1) begin failures++; $display("FAIL brk_from_idle_busy got=%b exp=1", busy_w[0]); end
        tick(); tick();
        send_break[0] = 1'b0;
        tick();
        checks++;
        if (tx_w[0] !== 1'b1) begin failures++; $display("FAIL brk_release_tx got=%b exp=1", tx_w[0]); end
        tick(); tick(); tick();
        checks++;
        if (busy_w[0] !== 1'b1) begin failures++; $display("FAIL brk_idle_hold got=%b exp=1", busy_w[0]); end
        tick();
        checks++;
        if (busy_w[0] !== 1'b0) begin failures++; $display("FAIL brk_idle_end got=%b exp=0", busy_w[0]); end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        test_reset();
        test_basic_frame();
        test_parity();
        test_fifo_full();
        test_same_edge_pop();
        test_reset_mid_frame();
        test_break();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
